// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the execute stage and muldiv_sequencer.
//   master : pipeline side; drives start/op/operands, flush and the MTHI/MTLO writes
//   slave  : sequencer side; returns busy, done, div_zero and the HI/LO registers
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_op1;
  logic [WIDTH-1:0] i_op2;
  logic             i_flush;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic             o_div_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_op1, i_op2, i_flush, i_hi_we, i_lo_we, i_wdata,
    input  o_busy, o_done, o_div_zero, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_op1, i_op2, i_flush, i_hi_we, i_lo_we, i_wdata,
    output o_busy, o_done, o_div_zero, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One radix-2 shift-add (multiply) or restoring-divide step per clock; WIDTH steps, then a
// fix-up cycle applies signs and writes HI/LO. Also services MTHI/MTLO while idle.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of muldiv_sequencer_if (start/op/operands/flush/MT writes in,
//             busy/done/div_zero/hi/lo out)
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic               i_clk,
  input logic               i_rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand, or divisor for divides
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;  // partial product high / partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;  // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0]   op1_q, op1_d;        // raw rs, returned as HI on divide by zero
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d;

  // Operand capture: signed ops work on magnitudes; -2^(W-1) maps to itself, read unsigned.
  logic             op_signed, s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  assign op_signed = ~bus.i_op[0];
  assign s1        = op_signed & bus.i_op1[WIDTH-1];
  assign s2        = op_signed & bus.i_op2[WIDTH-1];
  assign mag1      = s1 ? -bus.i_op1 : bus.i_op1;
  assign mag2      = s2 ? -bus.i_op2 : bus.i_op2;

  // Iteration datapath.
  logic [WIDTH:0]     sum, shifted, trial;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  assign sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  // Partial remainder stays below the divisor, so bit WIDTH is a valid borrow for nonzero divisors.
  assign trial    = shifted - {1'b0, mcand_q};
  assign prod_raw = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod_raw : prod_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    op1_d     = op1_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_hi_we) hi_d = bus.i_wdata;
        if (bus.i_lo_we) lo_d = bus.i_wdata;
        if (bus.i_start) begin
          state_d   = StCalc;
          cnt_d     = '0;
          is_div_d  = bus.i_op[1];
          mcand_d   = bus.i_op[1] ? mag2 : mag1;
          acc_lo_d  = bus.i_op[1] ? mag1 : mag2;
          acc_hi_d  = '0;
          op1_d     = bus.i_op1;
          neg_res_d = s1 ^ s2;
          neg_rem_d = s1;
        end
      end
      StCalc: begin
        if (is_div_q) begin
          acc_hi_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
          {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (mcand_q == '0) begin
          lo_d = '1;
          hi_d = op1_q;
          dz_d = 1'b1;
        end else begin
          lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush squashes any launch or in-flight op; only idle-state MT writes survive it.
    if (bus.i_flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      if (state_q != StIdle) begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      op1_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      op1_q     <= op1_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.o_busy     = (state_q != StIdle);
  assign bus.o_done     = done_q;
  assign bus.o_div_zero = dz_q;
  assign bus.o_hi       = hi_q;
  assign bus.o_lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: exact-latency checks of each op, sign/zero corner cases,
// MTHI/MTLO interaction, flush, ignored start/MT while busy, and asynchronous reset mid-op.
module tb_muldiv_sequencer;
  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nfail = 0;
  logic [31:0] lo_prev;
  bit   ok;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch at edge T; returns in cycle T+1.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_op    = op;
    bus.i_op1   = a;
    bus.i_op2   = b;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Full op: busy and stable HI/LO through T+1..T+33, done exactly at T+34.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    logic [31:0] hi0, lo0;
    bit good;
    hi0  = bus.o_hi;
    lo0  = bus.o_lo;
    good = 1'b1;
    start_op(op, a, b);
    for (int i = 0; i < 33; i++) begin
      if (!(bus.o_busy === 1'b1 && bus.o_done === 1'b0 && bus.o_div_zero === 1'b0 &&
            bus.o_hi === hi0 && bus.o_lo === lo0)) good = 1'b0;
      tick();
    end
    check({tag, " busy+stable"}, 64'(good), 64'd1);
    check({tag, " done/busy/dz"}, 64'({bus.o_done, bus.o_busy, bus.o_div_zero}),
          64'({1'b1, 1'b0, exp_dz}));
    check({tag, " hi:lo"}, {bus.o_hi, bus.o_lo}, {exp_hi, exp_lo});
    tick();
    check({tag, " pulse end"}, 64'({bus.o_done, bus.o_div_zero, bus.o_busy}), 64'd0);
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_op1   = '0;
    bus.i_op2   = '0;
    bus.i_flush = 1'b0;
    bus.i_hi_we = 1'b0;
    bus.i_lo_we = 1'b0;
    bus.i_wdata = '0;
    #2 rst_n = 1'b0;
    #10;
    check("reset flags", 64'({bus.o_busy, bus.o_done, bus.o_div_zero}), 64'd0);
    check("reset hi:lo", {bus.o_hi, bus.o_lo}, 64'd0);
    #3 rst_n = 1'b1;
    tick();

    run_op("multu max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult -3*5", OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("mult min*min", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
    run_op("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu 100/7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("div min/-1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    run_op("div 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
    run_op("divu 0x1234/0", OpDivu, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1);
    run_op("div -5/0", OpDiv, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);

    // MTHI in idle, then flush an in-flight MULTU at T+10.
    lo_prev     = bus.o_lo;
    bus.i_hi_we = 1'b1;
    bus.i_wdata = 32'h0000_AAAA;
    tick();
    bus.i_hi_we = 1'b0;
    check("mthi", {bus.o_hi, bus.o_lo}, {32'h0000_AAAA, lo_prev});
    start_op(OpMultu, 32'd3, 32'd4);
    repeat (9) tick();
    check("flush pre busy", 64'(bus.o_busy), 64'd1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("flush busy low", 64'({bus.o_busy, bus.o_done}), 64'd0);
    ok = 1'b1;
    repeat (30) begin
      tick();
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) ok = 1'b0;
    end
    check("flush no done", 64'(ok), 64'd1);
    check("flush hi:lo kept", {bus.o_hi, bus.o_lo}, {32'h0000_AAAA, lo_prev});

    // Start and MTLO during CALC are both ignored.
    start_op(OpMultu, 32'd3, 32'd4);
    tick();
    tick();
    bus.i_start = 1'b1;
    bus.i_op    = OpDivu;
    bus.i_op1   = 32'd100;
    bus.i_op2   = 32'd7;
    bus.i_lo_we = 1'b1;
    bus.i_wdata = 32'h0000_5555;
    tick();
    bus.i_start = 1'b0;
    bus.i_lo_we = 1'b0;
    check("mtlo in calc", 64'(bus.o_lo), 64'(lo_prev));
    repeat (30) tick();
    check("ignore done", 64'({bus.o_done, bus.o_busy}), 64'({1'b1, 1'b0}));
    check("ignore hi:lo", {bus.o_hi, bus.o_lo}, {32'h0, 32'd12});
    tick();
    check("no relaunch", 64'({bus.o_busy, bus.o_done}), 64'd0);

    // MTLO and start in the same idle cycle: write lands, completion overwrites.
    bus.i_lo_we = 1'b1;
    bus.i_wdata = 32'h0000_0077;
    start_op(OpDivu, 32'd9, 32'd2);
    bus.i_lo_we = 1'b0;
    check("mt+start lo", 64'({bus.o_busy, bus.o_lo}), 64'({1'b1, 32'h0000_0077}));
    repeat (33) tick();
    check("mt+start done", 64'({bus.o_done, bus.o_div_zero}), 64'({1'b1, 1'b0}));
    check("mt+start hi:lo", {bus.o_hi, bus.o_lo}, {32'd1, 32'd4});
    tick();

    // Flush and start together: nothing launched.
    bus.i_flush = 1'b1;
    start_op(OpMultu, 32'd6, 32'd7);
    bus.i_flush = 1'b0;
    check("flush+start", 64'({bus.o_busy, bus.o_done}), 64'd0);
    tick();
    check("flush+start later", 64'({bus.o_busy, bus.o_done, bus.o_lo}), 64'(32'd4));

    // Asynchronous reset at T+5 clears everything immediately.
    start_op(OpMultu, 32'd6, 32'd7);
    repeat (4) tick();
    check("pre reset busy", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset flags", 64'({bus.o_busy, bus.o_done, bus.o_div_zero}), 64'd0);
    check("async reset hi:lo", {bus.o_hi, bus.o_lo}, 64'd0);
    #3 rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      tick();
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) ok = 1'b0;
    end
    check("post reset quiet", 64'(ok), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
